// File: rtl/data_mem_arbiter_if.sv
// Handshake and memory-side bus between the two requesters, the arbiter and Data_Memory.
// slave = arbiter view, master = requesters plus the memory that answers mem_rdata.
interface data_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              gnt0;
    logic              gnt1;
    logic              rvalid0;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;
    logic              err0;
    logic              err1;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1,
               mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1,
               mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// Round-robin two-port sequencer for single-port Data_Memory: one access per ACCESS+RESP pair.
// Requests are held until gnt; ACCESS ignores req, so a port re-requests no earlier than RESP.
module data_mem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_DEPTH = 200
) (
    input  logic             clk,
    input  logic             reset,
    data_mem_arbiter_if.slave arb_if
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(MEM_DEPTH);

    state_t            state_q, state_d;
    logic              last_q, last_d;
    logic              win_q, win_d;
    logic              we_q, we_d;
    logic              oor_q, oor_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;

    logic              arb_vld;
    logic              arb_sel;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    logic              gnt0_o, gnt1_o, rvalid0_o, rvalid1_o, err0_o, err1_o;
    logic              mem_read_o, mem_write_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;

    // On a tie the port that was not served last wins; last_q resets to 1 so port 0 goes first.
    always_comb begin
        arb_vld   = arb_if.req0 | arb_if.req1;
        arb_sel   = arb_if.req1 & (~arb_if.req0 | ~last_q);
        sel_we    = arb_sel ? arb_if.we1    : arb_if.we0;
        sel_addr  = arb_sel ? arb_if.addr1  : arb_if.addr0;
        sel_wdata = arb_sel ? arb_if.wdata1 : arb_if.wdata0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            last_q   <= 1'b1;
            win_q    <= 1'b0;
            we_q     <= 1'b0;
            oor_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            win_q    <= win_d;
            we_q     <= we_d;
            oor_q    <= oor_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        win_d    = win_q;
        we_d     = we_q;
        oor_d    = oor_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        case (state_q)
            S_IDLE, S_RESP: begin
                if (arb_vld) begin
                    state_d = S_ACCESS;
                    win_d   = arb_sel;
                    last_d  = arb_sel;
                    we_d    = sel_we;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    oor_d   = !(sel_addr < DEPTH_A);
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACCESS: begin
                state_d = S_RESP;
                // Blocked accesses clear the winner's rdata; writes leave it alone.
                if (oor_q) begin
                    if (win_q) rdata1_d = '0;
                    else       rdata0_d = '0;
                end else if (!we_q) begin
                    if (win_q) rdata1_d = arb_if.mem_rdata;
                    else       rdata0_d = arb_if.mem_rdata;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Memory strobes decode straight from state so reset removes them in the same cycle.
    always_comb begin
        gnt0_o      = 1'b0;
        gnt1_o      = 1'b0;
        rvalid0_o   = 1'b0;
        rvalid1_o   = 1'b0;
        err0_o      = 1'b0;
        err1_o      = 1'b0;
        mem_read_o  = 1'b0;
        mem_write_o = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        case (state_q)
            S_ACCESS: begin
                gnt0_o = ~win_q;
                gnt1_o = win_q;
                if (!oor_q) begin
                    mem_read_o  = ~we_q;
                    mem_write_o = we_q;
                    mem_addr_o  = addr_q;
                    mem_wdata_o = wdata_q;
                end
            end
            S_RESP: begin
                rvalid0_o = ~win_q;
                rvalid1_o = win_q;
                err0_o    = ~win_q & oor_q;
                err1_o    = win_q & oor_q;
            end
            default: ;
        endcase
    end

    assign arb_if.gnt0      = gnt0_o;
    assign arb_if.gnt1      = gnt1_o;
    assign arb_if.rvalid0   = rvalid0_o;
    assign arb_if.rvalid1   = rvalid1_o;
    assign arb_if.err0      = err0_o;
    assign arb_if.err1      = err1_o;
    assign arb_if.rdata0    = rdata0_q;
    assign arb_if.rdata1    = rdata1_q;
    assign arb_if.mem_read  = mem_read_o;
    assign arb_if.mem_write = mem_write_o;
    assign arb_if.mem_addr  = mem_addr_o;
    assign arb_if.mem_wdata = mem_wdata_o;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Randomised scoreboard bench for data_mem_arbiter with a behavioural Data_Memory model.
module tb_data_mem_arbiter;
    localparam int DEPTH = 200;

    typedef struct {
        int unsigned gap;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    typedef struct {
        logic port;
        txn_t t;
    } resp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    data_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    data_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_DEPTH(DEPTH)) dut (
        .clk    (clk),
        .reset  (reset),
        .arb_if (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Data_Memory: combinational read, write at the rising edge while MemWrite is high.
    logic [31:0] mem [0:DEPTH-1];
    assign bus.mem_rdata = (bus.mem_addr < DEPTH) ? mem[bus.mem_addr[7:0]] : 32'd0;
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] <= 32'(i >> 1);
        forever begin
            @(posedge clk);
            if (bus.mem_write && bus.mem_addr < DEPTH) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
        end
    end

    txn_t script0[$], script1[$], issue0[$], issue1[$];
    resp_t resp_q[$];
    logic busy0 = 1'b0, busy1 = 1'b0;

    // Driver: holds each request until its gnt, then immediately offers the next one.
    initial begin
        txn_t t;
        bus.req0 = 0; bus.we0 = 0; bus.addr0 = 0; bus.wdata0 = 0;
        bus.req1 = 0; bus.we1 = 0; bus.addr1 = 0; bus.wdata1 = 0;
        forever begin
            @(negedge clk); #1;
            if (reset) begin
                busy0 = 0; busy1 = 0; bus.req0 = 0; bus.req1 = 0;
                script0.delete(); script1.delete(); issue0.delete(); issue1.delete();
            end else begin
                if (busy0 && bus.gnt0) begin busy0 = 0; bus.req0 = 0; end
                if (busy1 && bus.gnt1) begin busy1 = 0; bus.req1 = 0; end
                if (!busy0 && script0.size() > 0) begin
                    t = script0[0];
                    if (t.gap > 0) begin t.gap--; script0[0] = t; end
                    else begin
                        t = script0.pop_front();
                        bus.req0 = 1; bus.we0 = t.we; bus.addr0 = t.addr; bus.wdata0 = t.wdata;
                        issue0.push_back(t); busy0 = 1;
                    end
                end
                if (!busy1 && script1.size() > 0) begin
                    t = script1[0];
                    if (t.gap > 0) begin t.gap--; script1[0] = t; end
                    else begin
                        t = script1.pop_front();
                        bus.req1 = 1; bus.we1 = t.we; bus.addr1 = t.addr; bus.wdata1 = t.wdata;
                        issue1.push_back(t); busy1 = 1;
                    end
                end
            end
        end
    end

    // Monitor + reference model: memory is free every other cycle after a grant; ties go
    // to the port not served last; responses arrive one cycle after the grant.
    logic [31:0] ref_mem [0:DEPTH-1];
    logic [31:0] mrd0, mrd1;
    logic        model_last, gnt_prev;
    initial begin
        logic  r0, r1, exp_g, ew, oor, has_txn;
        txn_t  t;
        resp_t e;
        logic [31:0] exp_rd;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'(i >> 1);
        mrd0 = 0; mrd1 = 0; model_last = 1; gnt_prev = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                resp_q.delete(); gnt_prev = 0; model_last = 1; mrd0 = 0; mrd1 = 0;
                continue;
            end
            r0 = bus.req0; r1 = bus.req1;
            exp_g = !gnt_prev && (r0 || r1);
            chk("gnt_present", bus.gnt0 | bus.gnt1, exp_g);
            chk("gnt_onehot", bus.gnt0 & bus.gnt1, 0);
            if (exp_g) begin
                ew = (r0 && r1) ? !model_last : r1;
                chk("gnt_port", bus.gnt1, ew);
                model_last = ew;
                has_txn = ew ? (issue1.size() > 0) : (issue0.size() > 0);
                chk("gnt_has_txn", has_txn, 1);
                if (has_txn) begin
                    t = ew ? issue1.pop_front() : issue0.pop_front();
                    oor = t.addr >= DEPTH;
                    chk("mem_read", bus.mem_read, !t.we && !oor);
                    chk("mem_write", bus.mem_write, t.we && !oor);
                    if (!oor) chk("mem_addr", bus.mem_addr, t.addr);
                    if (!oor && t.we) chk("mem_wdata", bus.mem_wdata, t.wdata);
                    e.port = ew; e.t = t;
                    resp_q.push_back(e);
                end
            end else begin
                chk("mem_idle_strobe", {bus.mem_read, bus.mem_write}, 0);
                chk("mem_idle_addr", bus.mem_addr, 0);
            end
            chk("rvalid_present", bus.rvalid0 | bus.rvalid1, gnt_prev);
            chk("rvalid_onehot", bus.rvalid0 & bus.rvalid1, 0);
            if (gnt_prev && resp_q.size() > 0) begin
                e = resp_q.pop_front();
                oor = e.t.addr >= DEPTH;
                exp_rd = oor ? 32'd0 : (e.t.we ? (e.port ? mrd1 : mrd0) : ref_mem[e.t.addr[7:0]]);
                if (e.t.we && !oor) ref_mem[e.t.addr[7:0]] = e.t.wdata;
                if (e.port) mrd1 = exp_rd; else mrd0 = exp_rd;
                chk("rvalid_port", bus.rvalid1, e.port);
                chk("err", e.port ? bus.err1 : bus.err0, oor);
                chk("err_other", e.port ? bus.err0 : bus.err1, 0);
            end else begin
                chk("err_idle", {bus.err0, bus.err1}, 0);
            end
            chk("rdata0", bus.rdata0, mrd0);
            chk("rdata1", bus.rdata1, mrd1);
            gnt_prev = exp_g;
        end
    end

    function automatic txn_t mk(input int unsigned gap, input logic we,
                                input logic [31:0] addr, input logic [31:0] wdata);
        txn_t t;
        t.gap = gap; t.we = we; t.addr = addr; t.wdata = wdata;
        return t;
    endfunction

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (n < budget) begin
            @(negedge clk); #3;
            if (script0.size() == 0 && script1.size() == 0 && !busy0 && !busy1 &&
                resp_q.size() == 0) break;
            n++;
        end
        if (n >= budget) begin
            n_checks++;
            $display("FAIL drain_timeout: traffic still pending after %0d cycles", budget);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(negedge clk); #2 reset = 1;
        repeat (2) @(negedge clk);
        #2 reset = 0;
    endtask

    initial begin
        int n;
        logic [31:0] a;
        reset = 1;
        repeat (3) @(negedge clk);
        chk("rst_gnt", {bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.err0, bus.err1}, 0);
        chk("rst_mem", {bus.mem_read, bus.mem_write}, 0);
        chk("rst_rdata", {bus.rdata0, bus.rdata1}, 0);
        #2 reset = 0;

        script0.push_back(mk(0, 0, 10, 0));
        drain(50);
        chk("read10_rdata0", bus.rdata0, 32'd5);

        pulse_reset();
        script0.push_back(mk(0, 0, 30, 0));
        script1.push_back(mk(0, 0, 40, 0));
        drain(50);

        for (int i = 0; i < 3; i++) begin
            script0.push_back(mk(0, 0, 32'(50 + i), 0));
            script1.push_back(mk(0, 0, 32'(60 + i), 0));
        end
        drain(100);

        script1.push_back(mk(0, 1, 20, 32'hDEADBEEF));
        drain(50);
        script0.push_back(mk(0, 0, 20, 0));
        drain(50);
        chk("write_then_read", bus.rdata0, 32'hDEADBEEF);

        script0.push_back(mk(0, 0, 200, 0));
        drain(50);
        chk("oor_rdata0", bus.rdata0, 0);
        script0.push_back(mk(0, 0, 199, 0));
        drain(50);
        chk("last_legal_rdata0", bus.rdata0, 32'd99);

        // Reset during a write's ACCESS cycle must suppress the write.
        script0.push_back(mk(0, 1, 8, 32'h12345678));
        n = 0;
        while (n < 50) begin
            @(negedge clk);
            if (bus.gnt0) break;
            n++;
        end
        if (n >= 50) begin
            n_checks++;
            $display("FAIL gnt_timeout: no gnt0 for reset test");
        end
        #2 reset = 1;
        #1;
        chk("rst_mid_write", bus.mem_write, 0);
        chk("rst_mid_gnt", bus.gnt0, 0);
        chk("rst_mid_rdata0", bus.rdata0, 0);
        chk("rst_mid_addr", bus.mem_addr, 0);
        @(posedge clk); #1;
        chk("rst_word8", mem[8], 32'd4);
        repeat (2) @(negedge clk);
        #2 reset = 0;

        for (int i = 0; i < 300; i++) begin
            for (int p = 0; p < 2; p++) begin
                n = int'($urandom_range(0, 15));
                if (n == 0)      a = 32'd200;
                else if (n == 1) a = $urandom;
                else if (n == 2) a = 32'd199;
                else             a = 32'($urandom_range(0, DEPTH - 1));
                if (p == 0) script0.push_back(mk($urandom_range(0, 3), 1'($urandom), a, $urandom));
                else        script1.push_back(mk($urandom_range(0, 3), 1'($urandom), a, $urandom));
            end
        end
        drain(10000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
